// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RISC-V immediate scatter pipeline with write address.
// Define INSTR_ENC_RANGE_CHECK_EN to enable immediate range checking and err_cnt.
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       base_in,
    input  logic [31:0]       imm_in,
    input  logic [2:0]        imm_type_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr_out,
    output logic              err_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [7:0]        err_cnt
);
    logic              s1_full;
    logic [31:0]       s1_base;
    logic [31:0]       s1_imm;
    logic [2:0]        s1_type;
    logic              s1_err;
    logic              s2_full;
    logic              in_err;
    logic              s1_load;
    logic              s1_move;
    logic              s2_move;
    logic [31:0]       mask;
    logic [31:0]       field;
    logic [31:0]       word;
    logic [ADDR_W-1:0] addr_q;

    assign s2_move   = out_valid && out_ready;
    assign s1_move   = s1_full && (!s2_full || s2_move);
    assign in_ready  = rst_n && (!s1_full || s1_move);
    assign s1_load   = in_valid && in_ready;
    assign out_valid = rst_n && s2_full;
    assign addr_out  = addr_q;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic       sx12;
    logic       sx13;
    logic       sx21;
    logic [7:0] cnt_q;

    // Sign-extension checks: upper bits must all equal the field's sign bit.
    always_comb begin
        sx12 = (&imm_in[31:11]) || !(|imm_in[31:11]);
        sx13 = (&imm_in[31:12]) || !(|imm_in[31:12]);
        sx21 = (&imm_in[31:20]) || !(|imm_in[31:20]);
        case (imm_type_in)
            3'b001, 3'b010,
            3'b110, 3'b111: in_err = !sx12;
            3'b011:         in_err = !sx13 || imm_in[0];
            3'b100:         in_err = |imm_in[11:0];
            3'b101:         in_err = !sx21 || imm_in[0];
            default:        in_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (s2_move && err_out && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign err_cnt = cnt_q;
`else
    assign in_err  = 1'b0;
    assign err_cnt = 8'd0;
`endif

    always_comb begin
        mask  = 32'h0;
        field = 32'h0;
        case (s1_type)
            3'b001, 3'b110, 3'b111: begin
                mask  = 32'hFFF0_0000;
                field = {s1_imm[11:0], 20'b0};
            end
            3'b010: begin
                mask  = 32'hFE00_0F80;
                field = {s1_imm[11:5], 13'b0, s1_imm[4:0], 7'b0};
            end
            3'b011: begin
                mask  = 32'hFE00_0F80;
                field = {s1_imm[12], s1_imm[10:5], 13'b0,
                         s1_imm[4:1], s1_imm[11], 7'b0};
            end
            3'b100: begin
                mask  = 32'hFFFF_F000;
                field = {s1_imm[31:12], 12'b0};
            end
            3'b101: begin
                mask  = 32'hFFFF_F000;
                field = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                         s1_imm[19:12], 12'b0};
            end
            default: begin
                mask  = 32'h0;
                field = 32'h0;
            end
        endcase
        word = (s1_base & ~mask) | (s1_err ? 32'h0 : field);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_full   <= 1'b0;
            s1_base   <= 32'h0;
            s1_imm    <= 32'h0;
            s1_type   <= 3'b0;
            s1_err    <= 1'b0;
            s2_full   <= 1'b0;
            instr_out <= 32'h0;
            err_out   <= 1'b0;
            addr_q    <= '0;
        end else begin
            if (s1_load) begin
                s1_full <= 1'b1;
                s1_base <= base_in;
                s1_imm  <= imm_in;
                s1_type <= imm_type_in;
                s1_err  <= in_err;
            end else if (s1_move) begin
                s1_full <= 1'b0;
            end
            if (s1_move) begin
                s2_full   <= 1'b1;
                instr_out <= word;
                err_out   <= s1_err;
            end else if (s2_move) begin
                s2_full <= 1'b0;
            end
            if (s2_move) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end
endmodule
